// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_CTRL_W = 8;
  localparam int unsigned PIPE_DATA_W = 111;
  localparam int unsigned PIPE_STAT_W = 16;

  // Decode->Execute control field layout within in_ctrl
  localparam int unsigned DE_REGWRITE   = 7;
  localparam int unsigned DE_MEMTOREG   = 6;
  localparam int unsigned DE_MEMWRITE   = 5;
  localparam int unsigned DE_ALUSRC     = 4;
  localparam int unsigned DE_REGDST     = 3;
  localparam int unsigned DE_ALUCTRL_HI = 2;
  localparam int unsigned DE_ALUCTRL_LO = 0;

  function automatic logic state_has_room(input pipe_state_e s);
    return (s != ST_TWO);
  endfunction

endpackage

// File: rtl/pipe_stat_ctr.sv
// Generic saturating event counter; holds at all-ones, cleared only by reset.
module pipe_stat_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned W = PIPE_STAT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] INC_ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + INC_ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and bubble statistics.
// Define PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned STAT_W = PIPE_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] stat_bubbles
);

  logic bubble;
  assign bubble = out_ready && !out_valid;

  pipe_stat_ctr #(.W(STAT_W)) u_stat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble),
    .cnt   (stat_bubbles)
  );

`ifdef PIPE_SKID_EN
  // state    | meaning
  // ST_EMPTY | nothing held, out_valid=0
  // ST_ONE   | main entry valid, skid empty
  // ST_TWO   | main and skid valid, upstream blocked

  pipe_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, take;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign accept    = in_valid && in_ready_q;
  assign take      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_TWO;
          end else if (take) begin
            main_ctrl_d = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a take can move us
          if (take) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = ST_ONE;
          end
        end
        default: begin
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
          state_d     = ST_EMPTY;
        end
      endcase
    end

    in_ready_d = state_has_room(state_d);
  end

`else
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready  = out_ready || !valid_q;
  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      ctrl_q  <= in_ctrl;
      data_q  <= in_data;
    end else if (out_ready && valid_q) begin
      // data keeps its last value; only ctrl must read as NOP
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush into a NOP bubble, and an optional skid buffer. It replaces the fixed-field stage registers between pipeline stages (Decode→Execute first, then Execute→Memory and Memory→Writeback). Control and data travel as two packed fields, so one block serves every stage boundary. Backpressure from a stalled downstream stage propagates upstream without losing or duplicating an instruction.

## Interface
Parameters:
- CTRL_W, 8: width of control field (regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0]); zeroed in every bubble.
- DATA_W, 111: width of data field (rd1, rd2, signimm, rs, rt, rd).
- STAT_W, 16: width of bubble statistics counter.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; discards all held entries and inserts a bubble.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block accepts an entry this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts an entry this cycle.
- out_ctrl  out  CTRL_W  downstream control field.
- out_data  out  DATA_W  downstream data field.
- stat_bubbles  out  STAT_W  saturating count of bubble cycles.

## Operation
- Accept: in_valid && in_ready at a rising edge. Take: out_valid && out_ready at a rising edge.
- Invariant: out_valid=0 implies out_ctrl=0, so every bubble is a NOP. out_data is unspecified but deterministic: zero after reset or flush, otherwise last value.
- Without skid: a single entry. in_ready = out_ready || !out_valid (combinational). An accept loads the entry; a take without an accept clears out_valid and out_ctrl.
- With skid: main entry plus skid entry. States are EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept with take → ONE (new entry in main). Accept without take → TWO (new entry in skid). Take only → EMPTY.
  - TWO: take → ONE (skid moves to main). No accept is possible.
  - in_ready is registered: 1 in EMPTY and ONE, 0 in TWO.
- Flush has priority over everything. At that edge all entries are invalidated, ctrl and data are zeroed, and state goes to EMPTY. A same-cycle accept is dropped. A same-cycle take is still consumed downstream.
- Entries leave in strict arrival order. No entry is duplicated or reordered.
- stat_bubbles increments on every edge where out_ready=1 and out_valid=0. It saturates at all-ones and is cleared only by reset; flush does not clear it.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, out_ctrl=0, out_data=0, in_ready=1, state EMPTY, stat_bubbles=0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 entry/cycle in both modes while out_ready=1.
- With skid: in_ready has no combinational path from out_ready. Up to 2 entries are held.
- Without skid: out_ready→in_ready is a combinational path of one gate level.
- A flush issued at edge N gives out_valid=0 at N+0⁺, and in_ready=1 afterwards.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer with a registered in_ready.
- PIPE_SKID_EN undefined: single entry with a combinational in_ready. The skid entry and state register are not synthesised.
- Port list is identical in both modes.

## Structure
- pipe_pkg holds the following:
  - the state enum (EMPTY, ONE, TWO);
  - default CTRL_W, DATA_W and STAT_W constants;
  - the bit positions of the Decode→Execute control fields within in_ctrl.
- Sub-module pipe_stat_ctr: a generic STAT_W saturating counter with an inc input, used for stat_bubbles.

## Test plan
- Reset mid-stream: rst_n low for 1 cycle while in state TWO → out_valid=0, out_ctrl=0, in_ready=1, stat_bubbles=0 immediately.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with data 0..9 → outputs 0..9 in order, one cycle after each accept, no bubbles.
- Backpressure (skid): out_ready=0 while 3 entries are offered → entries 0 and 1 are accepted and in_ready falls to 0. Then out_ready=1 → outputs 0, 1, 2 in order with nothing lost.
- Flush collision: flush=1 with in_valid=1, in_ctrl=8'hFF, in state TWO → next cycle out_valid=0, out_ctrl=0, and the entry is dropped.
- Bubble count: out_ready=1 and in_valid=0 for 5 cycles → stat_bubbles=5. Force a value of 16'hFFFF, then one more bubble → stays 16'hFFFF.
- Non-skid build: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. Raise out_ready → in_ready=1 combinationally.
